// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar frame scheduler.
// The optional ping-pong sweep is selected with the BIDIR_SWEEP_EN macro.
package sonar_pkg;

  localparam int unsigned ANGLE_WIDTH = 8;
  localparam int unsigned RANGE_WIDTH = 16;

  localparam int unsigned BURST_CYCLES_DEF  = 524288;
  localparam int unsigned LISTEN_CYCLES_DEF = 16252928;
  localparam int unsigned SETTLE_CYCLES_DEF = 1024;

  localparam int ANGLE_MIN_DEF  = -30;
  localparam int ANGLE_MAX_DEF  = 30;
  localparam int ANGLE_STEP_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    LISTEN = 2'd2,
    SETTLE = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic signed [ANGLE_WIDTH-1:0] angle;
    logic [RANGE_WIDTH-1:0]        range;
    logic                          echo;
  } sonar_result_t;

  // Largest of three window lengths; sizes the shared window counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/angle_stepper.sv
// Beam steering angle register with sweep advance.
// BIDIR_SWEEP_EN: ping-pong sweep with a direction register; otherwise sawtooth.
module angle_stepper
  import sonar_pkg::*;
#(
  parameter int ANGLE_MIN  = ANGLE_MIN_DEF,
  parameter int ANGLE_MAX  = ANGLE_MAX_DEF,
  parameter int ANGLE_STEP = ANGLE_STEP_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          advance_in,
  input  logic                          hold_in,
  output logic signed [ANGLE_WIDTH-1:0] angle_out,
  output logic                          at_end_out
);

  // One bit of headroom so MAX+STEP / MIN-STEP never wraps before the compare.
  localparam int unsigned WW = ANGLE_WIDTH + 1;
  localparam logic signed [WW-1:0] MIN_W  = WW'(ANGLE_MIN);
  localparam logic signed [WW-1:0] MAX_W  = WW'(ANGLE_MAX);
  localparam logic signed [WW-1:0] STEP_W = WW'(ANGLE_STEP);
`ifdef BIDIR_SWEEP_EN
  localparam logic AT_END_RST = 1'b1;
`else
  localparam logic AT_END_RST = (ANGLE_MIN == ANGLE_MAX);
`endif

  logic signed [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic                          at_end_q, at_end_d;
  logic signed [WW-1:0]          angle_w, up_w, dn_w, next_w;
  logic                          step_c;
`ifdef BIDIR_SWEEP_EN
  logic                          dir_up_q, dir_up_d;
`endif

  assign angle_w = WW'(angle_q);
  assign up_w    = angle_w + STEP_W;
  assign dn_w    = angle_w - STEP_W;
  assign step_c  = advance_in && !hold_in;

  // Next angle: step along the sweep, turning or wrapping at the ends.
  always_comb begin
    next_w = angle_w;
`ifdef BIDIR_SWEEP_EN
    dir_up_d = dir_up_q;
    if (step_c) begin
      if (dir_up_q) begin
        if (angle_w >= MAX_W) begin
          next_w   = dn_w;
          dir_up_d = 1'b0;
        end else begin
          next_w = up_w;
        end
      end else begin
        if (angle_w <= MIN_W) begin
          next_w   = up_w;
          dir_up_d = 1'b1;
        end else begin
          next_w = dn_w;
        end
      end
    end
    at_end_d = (next_w == MAX_W) || (next_w == MIN_W);
`else
    if (step_c) begin
      next_w = (angle_w >= MAX_W) ? MIN_W : up_w;
    end
    at_end_d = (next_w == MAX_W);
`endif
    angle_d = ANGLE_WIDTH'(next_w);
  end

  // Angle, end flag and direction registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      angle_q  <= ANGLE_WIDTH'(ANGLE_MIN);
      at_end_q <= AT_END_RST;
`ifdef BIDIR_SWEEP_EN
      dir_up_q <= 1'b1;
`endif
    end else begin
      angle_q  <= angle_d;
      at_end_q <= at_end_d;
`ifdef BIDIR_SWEEP_EN
      dir_up_q <= dir_up_d;
`endif
    end
  end

  assign angle_out  = angle_q;
  assign at_end_out = at_end_q;

endmodule

// File: rtl/sonar_frame_scheduler.sv
// Sonar ping frame sequencer: burst, listen, settle; captures the first echo
// range per frame into a one-entry valid/ready result buffer.
// BIDIR_SWEEP_EN selects the ping-pong angle sweep (default: sawtooth).
module sonar_frame_scheduler
  import sonar_pkg::*;
#(
  parameter int unsigned BURST_CYCLES  = BURST_CYCLES_DEF,
  parameter int unsigned LISTEN_CYCLES = LISTEN_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int          ANGLE_MIN     = ANGLE_MIN_DEF,
  parameter int          ANGLE_MAX     = ANGLE_MAX_DEF,
  parameter int          ANGLE_STEP    = ANGLE_STEP_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          hold_angle_in,
  input  logic                          tof_valid_in,
  input  logic [RANGE_WIDTH-1:0]        range_in,
  output logic                          burst_active_out,
  output logic                          burst_start_out,
  output logic                          listen_active_out,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                          result_valid_out,
  input  logic                          result_ready_in,
  output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
  output logic [RANGE_WIDTH-1:0]        result_range_out,
  output logic                          result_echo_out,
  output logic                          sweep_done_out,
  output logic                          overrun_out
);

  localparam int unsigned CNT_MAX = max3(BURST_CYCLES, LISTEN_CYCLES, SETTLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  frame_state_t           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   echo_q, echo_d;
  logic [RANGE_WIDTH-1:0] range_q, range_d;
  sonar_result_t          res_q, res_d;
  logic                   res_valid_q, res_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   sweep_done_q, sweep_done_d;
  logic                   burst_active_q, burst_active_d;
  logic                   burst_start_q, burst_start_d;
  logic                   listen_active_q, listen_active_d;

  sonar_result_t                 push_res_c;
  logic                          push_c;
  logic                          accept_c;
  logic signed [ANGLE_WIDTH-1:0] angle_c;
  logic                          at_end_c;

  angle_stepper #(
    .ANGLE_MIN  (ANGLE_MIN),
    .ANGLE_MAX  (ANGLE_MAX),
    .ANGLE_STEP (ANGLE_STEP)
  ) u_angle_stepper (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .advance_in (push_c),
    .hold_in    (hold_angle_in),
    .angle_out  (angle_c),
    .at_end_out (at_end_c)
  );

  // Frame sequencing, echo capture and result buffer next-state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    echo_d       = echo_q;
    range_d      = range_q;
    res_d        = res_q;
    res_valid_d  = res_valid_q;
    overrun_d    = overrun_q;
    sweep_done_d = 1'b0;
    push_c       = 1'b0;
    push_res_c   = '0;
    accept_c     = res_valid_q && result_ready_in;

    if (accept_c) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_in) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (cnt_q == BURST_LAST) begin
          state_d = LISTEN;
          cnt_d   = '0;
        end
      end
      LISTEN: begin
        if (tof_valid_in && !echo_q) begin
          echo_d  = 1'b1;
          range_d = range_in;
        end
        if (cnt_q == LISTEN_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
          push_c  = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = enable_in ? BURST : IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // End of listen: hand the frame result to the buffer (an echo on the
    // last listen cycle is already folded into echo_d/range_d).
    if (push_c) begin
      push_res_c.angle = angle_c;
      push_res_c.echo  = echo_d;
      push_res_c.range = echo_d ? range_d : '1;
      if (!res_valid_q || accept_c) begin
        res_d       = push_res_c;
        res_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      sweep_done_d = at_end_c;
    end

    // Fresh capture slot for every frame.
    if ((state_d == BURST) && (state_q != BURST)) begin
      echo_d  = 1'b0;
      range_d = '0;
    end

    burst_active_d  = (state_d == BURST);
    burst_start_d   = (state_d == BURST) && (state_q != BURST);
    listen_active_d = (state_d == LISTEN);
  end

  // State, counter, capture, buffer and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      echo_q          <= 1'b0;
      range_q         <= '0;
      res_q           <= '0;
      res_valid_q     <= 1'b0;
      overrun_q       <= 1'b0;
      sweep_done_q    <= 1'b0;
      burst_active_q  <= 1'b0;
      burst_start_q   <= 1'b0;
      listen_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      echo_q          <= echo_d;
      range_q         <= range_d;
      res_q           <= res_d;
      res_valid_q     <= res_valid_d;
      overrun_q       <= overrun_d;
      sweep_done_q    <= sweep_done_d;
      burst_active_q  <= burst_active_d;
      burst_start_q   <= burst_start_d;
      listen_active_q <= listen_active_d;
    end
  end

  assign burst_active_out  = burst_active_q;
  assign burst_start_out   = burst_start_q;
  assign listen_active_out = listen_active_q;
  assign beam_angle_out    = angle_c;
  assign result_valid_out  = res_valid_q;
  assign result_angle_out  = res_q.angle;
  assign result_range_out  = res_q.range;
  assign result_echo_out   = res_q.echo;
  assign sweep_done_out    = sweep_done_q;
  assign overrun_out       = overrun_q;

endmodule

// File: tb/tb_sonar_frame_scheduler.sv
// Self-checking bench for sonar_frame_scheduler with short windows (4/20/2).
// Honours BIDIR_SWEEP_EN for the expected sweep order.
module tb_sonar_frame_scheduler;

  localparam int B     = 4;
  localparam int L     = 20;
  localparam int S     = 2;
  localparam int F     = B + L + S;
  localparam int AMIN  = -30;
  localparam int AMAX  = 30;
  localparam int ASTEP = 10;
  localparam int N     = (AMAX - AMIN) / ASTEP + 1;
`ifdef BIDIR_SWEEP_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif
  localparam int PERIOD = BIDIR ? (2 * N - 2) : N;

  logic              clk;
  logic              rst;
  logic              en;
  logic              hold;
  logic              tof;
  logic [15:0]       rng;
  logic              ready;
  logic              burst_active_out;
  logic              burst_start_out;
  logic              listen_active_out;
  logic signed [7:0] beam_angle_out;
  logic              result_valid_out;
  logic signed [7:0] result_angle_out;
  logic [15:0]       result_range_out;
  logic              result_echo_out;
  logic              sweep_done_out;
  logic              overrun_out;

  int n_cmp = 0;
  int n_bad = 0;

  sonar_frame_scheduler #(
    .BURST_CYCLES  (B),
    .LISTEN_CYCLES (L),
    .SETTLE_CYCLES (S),
    .ANGLE_MIN     (AMIN),
    .ANGLE_MAX     (AMAX),
    .ANGLE_STEP    (ASTEP)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .enable_in         (en),
    .hold_angle_in     (hold),
    .tof_valid_in      (tof),
    .range_in          (rng),
    .burst_active_out  (burst_active_out),
    .burst_start_out   (burst_start_out),
    .listen_active_out (listen_active_out),
    .beam_angle_out    (beam_angle_out),
    .result_valid_out  (result_valid_out),
    .result_ready_in   (ready),
    .result_angle_out  (result_angle_out),
    .result_range_out  (result_range_out),
    .result_echo_out   (result_echo_out),
    .sweep_done_out    (sweep_done_out),
    .overrun_out       (overrun_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, $signed(got), got, $signed(exp), exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame position: -1 idle, else 0..F-1 within the frame.
  // Sweep position k walks 0..PERIOD-1; the angle is a fold of k onto the grid.
  int m_pos, m_k, m_caprng, m_ra, m_rr, m_cur;
  bit m_cap, m_rv, m_re, m_sd, m_ovr;

  function automatic int angle_of(input int k);
    int idx;
    idx = (k < N) ? k : (2 * N - 2 - k);
    return AMIN + idx * ASTEP;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = -1; m_k = 0; m_cap = 0; m_caprng = 0;
      m_rv = 0; m_ra = 0; m_rr = 0; m_re = 0; m_sd = 0; m_ovr = 0;
    end else begin
      m_sd = 0;
      if (m_rv && ready) m_rv = 0;
      if (m_pos >= B && m_pos < B + L && tof && !m_cap) begin
        m_cap = 1; m_caprng = int'(rng);
      end
      if (m_pos == B + L - 1) begin
        m_cur = angle_of(m_k);
        if (m_rv) m_ovr = 1;
        else begin
          m_rv = 1; m_ra = m_cur; m_re = m_cap;
          m_rr = m_cap ? m_caprng : 'hFFFF;
        end
        m_sd = (m_cur == AMAX) || (BIDIR && m_cur == AMIN);
        if (!hold) m_k = (m_k + 1) % PERIOD;
      end
      if (m_pos < 0 || m_pos == F - 1) m_pos = en ? 0 : -1;
      else m_pos = m_pos + 1;
      if (m_pos == 0) m_cap = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("burst_active", 32'(burst_active_out), 32'(m_pos >= 0 && m_pos < B));
    chk("burst_start", 32'(burst_start_out), 32'(m_pos == 0));
    chk("listen_active", 32'(listen_active_out), 32'(m_pos >= B && m_pos < B + L));
    chk("beam_angle", 32'($signed(beam_angle_out)), 32'(angle_of(m_k)));
    chk("result_valid", 32'(result_valid_out), 32'(m_rv));
    chk("sweep_done", 32'(sweep_done_out), 32'(m_sd));
    chk("overrun", 32'(overrun_out), 32'(m_ovr));
    if (m_rv) begin
      chk("result_angle", 32'($signed(result_angle_out)), 32'(m_ra));
      chk("result_range", 32'(result_range_out), 32'(m_rr));
      chk("result_echo", 32'(result_echo_out), 32'(m_re));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one full frame starting at frame position 0; tN = listen index of
  // an echo (99 = none). Returns cycle counts of burst/listen/sweep_done.
  task automatic do_frame(input int t1, input logic [15:0] r1,
                          input int t2, input logic [15:0] r2,
                          input bit btof, input bit drain, input bit rdy, input bit hld,
                          output int nb, output int nl, output int nsd);
    nb = 0; nl = 0; nsd = 0;
    for (int p = 0; p < F; p++) begin
      nb  += int'(burst_active_out);
      nl  += int'(listen_active_out);
      nsd += int'(sweep_done_out);
      tof   = (p == B + t1) || (p == B + t2) || (btof && p == 1);
      rng   = (p == B + t1) ? r1 : (p == B + t2) ? r2 : (16'hBAD0 ^ 16'(p));
      ready = (p == 0) ? drain : rdy;
      hold  = (p == B + L - 1) ? hld : 1'b0;
      tick();
    end
    tof = 1'b0; hold = 1'b0;
  endtask

  int nb, nl, nsd, nstart;

  initial begin
    rst = 1'b1; en = 1'b0; hold = 1'b0; tof = 1'b0; rng = '0; ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_burst_active", 32'(burst_active_out), 32'd0);
    chk("rst_result_valid", 32'(result_valid_out), 32'd0);
    chk("rst_overrun", 32'(overrun_out), 32'd0);
    chk("rst_beam_angle", 32'($signed(beam_angle_out)), 32'(-30));

    // Frame 1: first echo wins, burst-time tof ignored, result held.
    en = 1'b1;
    tick();
    chk("f1_burst_start", 32'(burst_start_out), 32'd1);
    chk("f1_burst_active", 32'(burst_active_out), 32'd1);
    do_frame(5, 16'h0123, 9, 16'h0456, 1'b1, 1'b0, 1'b0, 1'b0, nb, nl, nsd);
    chk("f1_burst_cycles", 32'(nb), 32'd4);
    chk("f1_listen_cycles", 32'(nl), 32'd20);
    chk("f1_sweep_done", 32'(nsd), 32'(BIDIR ? 1 : 0));
    chk("f1_valid", 32'(result_valid_out), 32'd1);
    chk("f1_res_angle", 32'($signed(result_angle_out)), 32'(-30));
    chk("f1_res_range", 32'(result_range_out), 32'h0123);
    chk("f1_res_echo", 32'(result_echo_out), 32'd1);
    chk("f1_next_angle", 32'($signed(beam_angle_out)), 32'(-20));

    // Frame 2: no echo in listen -> timeout result.
    do_frame(99, 16'h0, 99, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, nb, nl, nsd);
    chk("f2_valid", 32'(result_valid_out), 32'd1);
    chk("f2_res_angle", 32'($signed(result_angle_out)), 32'(-20));
    chk("f2_res_range", 32'(result_range_out), 32'hFFFF);
    chk("f2_res_echo", 32'(result_echo_out), 32'd0);

    // Frames 3..7: finish the sweep up to +30.
    for (int i = 0; i < 5; i++) begin
      do_frame(int'($urandom_range(L - 1)), 16'($urandom), 99, 16'h0,
               1'b0, 1'b1, 1'b1, 1'b0, nb, nl, nsd);
      chk("sweep_done_count", 32'(nsd), 32'(i == 4 ? 1 : 0));
    end
    chk("after_sweep_angle", 32'($signed(beam_angle_out)), 32'(BIDIR ? 20 : -30));

    // Frames 8/9: consumer stalled for two frames -> second result dropped.
    do_frame(3, 16'h1111, 99, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, nb, nl, nsd);
    chk("f8_res_angle", 32'($signed(result_angle_out)), 32'(BIDIR ? 20 : -30));
    do_frame(4, 16'h2222, 99, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, nb, nl, nsd);
    chk("f9_valid", 32'(result_valid_out), 32'd1);
    chk("f9_held_range", 32'(result_range_out), 32'h1111);
    chk("f9_overrun", 32'(overrun_out), 32'd1);
    do_frame(6, 16'h3333, 99, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, nb, nl, nsd);
    chk("f10_valid", 32'(result_valid_out), 32'd0);
    chk("f10_overrun_sticky", 32'(overrun_out), 32'd1);

    // Frame 11: hold the angle at frame end.
    do_frame(L - 1, 16'h4444, 99, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, nb, nl, nsd);
    chk("f11_res_angle", 32'($signed(result_angle_out)), 32'(BIDIR ? -10 : 0));
    chk("f11_last_cycle_echo", 32'(result_range_out), 32'h4444);
    chk("f11_held_angle", 32'($signed(beam_angle_out)), 32'(BIDIR ? -10 : 0));

    // Enable drops mid-frame: frame completes, nothing new starts.
    ready = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    nstart = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      nstart += int'(burst_start_out);
    end
    chk("disable_no_restart", 32'(nstart), 32'd0);
    chk("disable_idle", 32'(burst_active_out | listen_active_out), 32'd0);

    // Reset in the middle of LISTEN.
    en = 1'b1;
    tick();
    repeat (B + 7) tick();
    chk("pre_rst_listen", 32'(listen_active_out), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_listen", 32'(listen_active_out), 32'd0);
    chk("rst_mid_angle", 32'($signed(beam_angle_out)), 32'(-30));
    chk("rst_mid_overrun", 32'(overrun_out), 32'd0);
    chk("rst_mid_res_range", 32'(result_range_out), 32'd0);
    tick();
    rst = 1'b0;

    // Randomised traffic against the model.
    en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63) == 0) en = ~en;
      tof   = ($urandom_range(7) == 0);
      rng   = 16'($urandom);
      ready = 1'($urandom_range(1));
      hold  = ($urandom_range(7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
